// File: rtl/psg_multi.sv
// psg_multi: NUM_CH square-wave tone channels plus one LFSR noise channel, each tone
// shaped by an attack/sustain/release envelope, mixed and emitted as 1-bit PWM audio.
module psg_multi #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned PER_W     = 12,
    parameter int unsigned ENV_SHIFT = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write_strobe,
    input  logic [4:0] address,
    input  logic [7:0] data,
    output logic       signal_out,
    output logic [6:0] debug
);
    localparam int unsigned MIX_W  = 4 + $clog2(NUM_CH + 1);
    localparam int unsigned DBG_CH = (NUM_CH < 4) ? NUM_CH : 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ATTACK  = 2'b01,
        SUSTAIN = 2'b10,
        RELEASE = 2'b11
    } env_state_e;

    logic [7:0]       shadow_q    [NUM_CH];
    logic [7:0]       shadow_d    [NUM_CH];
    logic [PER_W-1:0] period_q    [NUM_CH];
    logic [PER_W-1:0] period_d    [NUM_CH];
    logic [PER_W-1:0] cnt_q       [NUM_CH];
    logic [PER_W-1:0] cnt_d       [NUM_CH];
    logic [3:0]       vol_q       [NUM_CH];
    logic [3:0]       vol_d       [NUM_CH];
    logic [3:0]       rate_q      [NUM_CH];
    logic [3:0]       rate_d      [NUM_CH];
    logic [3:0]       rate_cnt_q  [NUM_CH];
    logic [3:0]       rate_cnt_d  [NUM_CH];
    logic [3:0]       level_q     [NUM_CH];
    logic [3:0]       level_d     [NUM_CH];
    logic             gate_q      [NUM_CH];
    logic             gate_d      [NUM_CH];
    logic             gate_prev_q [NUM_CH];
    logic             gate_prev_d [NUM_CH];
    logic             env_en_q    [NUM_CH];
    logic             env_en_d    [NUM_CH];
    logic             wave_q      [NUM_CH];
    logic             wave_d      [NUM_CH];
    env_state_e       state_q     [NUM_CH];
    env_state_e       state_d     [NUM_CH];

    logic [NUM_CH-1:0]    en_q, en_d;
    logic                 noise_en_q, noise_en_d;
    logic [7:0]           noise_per_q, noise_per_d;
    logic [3:0]           noise_vol_q, noise_vol_d;
    logic [7:0]           noise_div_q, noise_div_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [ENV_SHIFT-1:0] presc_q, presc_d;
    logic [MIX_W-1:0]     mix_q, mix_d;
    logic [MIX_W-1:0]     pwm_q, pwm_d;
    logic                 out_q, out_d;
    logic [6:0]           dbg_q, dbg_d;

    logic             tick, step, rise, fall;
    logic [4:0]       level_inc;
    logic [MIX_W-1:0] sum;
    logic [3:0]       wave_vec;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned,
    // which is what keeps this block free of inferred latches.
    always_comb begin
        tick        = &presc_q;
        presc_d     = presc_q + 1'b1;
        en_d        = en_q;
        noise_en_d  = noise_en_q;
        noise_per_d = noise_per_q;
        noise_vol_d = noise_vol_q;
        step        = 1'b0;
        rise        = 1'b0;
        fall        = 1'b0;
        level_inc   = '0;
        sum         = '0;
        wave_vec    = '0;

        if (noise_div_q == noise_per_q) begin
            noise_div_d = '0;
            lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end else begin
            noise_div_d = noise_div_q + 1'b1;
            lfsr_d      = lfsr_q;
        end

        for (int c = 0; c < NUM_CH; c++) begin
            shadow_d[c]    = shadow_q[c];
            period_d[c]    = period_q[c];
            vol_d[c]       = vol_q[c];
            gate_d[c]      = gate_q[c];
            env_en_d[c]    = env_en_q[c];
            rate_d[c]      = rate_q[c];
            gate_prev_d[c] = gate_q[c];

            if (period_q[c] == '0) begin
                cnt_d[c]  = '0;
                wave_d[c] = 1'b0;
            end else if (cnt_q[c] >= period_q[c] - 1'b1) begin
                cnt_d[c]  = '0;
                wave_d[c] = ~wave_q[c];
            end else begin
                cnt_d[c]  = cnt_q[c] + 1'b1;
                wave_d[c] = wave_q[c];
            end

            // Gate edges take priority over envelope steps landing in the same cycle.
            rise          = gate_q[c] & ~gate_prev_q[c];
            fall          = ~gate_q[c] & gate_prev_q[c];
            step          = tick && (rate_cnt_q[c] == rate_q[c]);
            level_inc     = {1'b0, level_q[c]} + 5'd1;
            state_d[c]    = state_q[c];
            level_d[c]    = level_q[c];
            rate_cnt_d[c] = tick ? (step ? 4'd0 : rate_cnt_q[c] + 4'd1) : rate_cnt_q[c];
            if (!env_en_q[c]) begin
                state_d[c]    = IDLE;
                level_d[c]    = vol_q[c];
                rate_cnt_d[c] = 4'd0;
            end else if (rise) begin
                state_d[c] = ATTACK;
            end else if (fall && (state_q[c] == ATTACK || state_q[c] == SUSTAIN)) begin
                state_d[c] = RELEASE;
            end else begin
                case (state_q[c])
                    IDLE:    level_d[c] = '0;
                    ATTACK:  if (step) begin
                        if (level_inc >= {1'b0, vol_q[c]}) begin
                            level_d[c] = vol_q[c];
                            state_d[c] = SUSTAIN;
                        end else begin
                            level_d[c] = level_inc[3:0];
                        end
                    end
                    SUSTAIN: level_d[c] = vol_q[c];
                    RELEASE: if (step) begin
                        if (level_q[c] <= 4'd1) begin
                            level_d[c] = '0;
                            state_d[c] = IDLE;
                        end else begin
                            level_d[c] = level_q[c] - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end

            if (write_strobe && address[4:2] == 3'(c)) begin
                case (address[1:0])
                    2'd0:    shadow_d[c] = data;
                    2'd1:    period_d[c] = {data[PER_W-9:0], shadow_q[c]};
                    2'd2:    vol_d[c]    = data[3:0];
                    default: begin
                        gate_d[c]   = data[7];
                        env_en_d[c] = data[6];
                        rate_d[c]   = data[3:0];
                    end
                endcase
            end

            if (en_q[c] && wave_q[c]) sum = sum + MIX_W'(level_q[c]);
        end

        for (int c = 0; c < DBG_CH; c++) wave_vec[c] = wave_q[c];

        if (write_strobe) begin
            case (address)
                5'd28:   noise_per_d = data;
                5'd29:   noise_vol_d = data[3:0];
                5'd30:   begin
                    en_d       = data[NUM_CH-1:0];
                    noise_en_d = data[7];
                end
                default: ;
            endcase
        end

        if (noise_en_q && lfsr_q[0]) sum = sum + MIX_W'(noise_vol_q);
        mix_d = sum;
        pwm_d = pwm_q + 1'b1;
        out_d = (pwm_q < mix_q);
        // Debug is registered so it reads all-zero during reset despite the nonzero seed.
        dbg_d = {state_q[0], lfsr_q[0], wave_vec};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays are control registers, not RAM, and must
            // all clear on reset, so they are reset here element by element.
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_q[c]    <= '0;
                period_q[c]    <= '0;
                cnt_q[c]       <= '0;
                vol_q[c]       <= '0;
                rate_q[c]      <= '0;
                rate_cnt_q[c]  <= '0;
                level_q[c]     <= '0;
                gate_q[c]      <= 1'b0;
                gate_prev_q[c] <= 1'b0;
                env_en_q[c]    <= 1'b0;
                wave_q[c]      <= 1'b0;
                state_q[c]     <= IDLE;
            end
            en_q        <= '0;
            noise_en_q  <= 1'b0;
            noise_per_q <= '0;
            noise_vol_q <= '0;
            noise_div_q <= '0;
            lfsr_q      <= LFSR_SEED;
            presc_q     <= '0;
            mix_q       <= '0;
            pwm_q       <= '0;
            out_q       <= 1'b0;
            dbg_q       <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_q[c]    <= shadow_d[c];
                period_q[c]    <= period_d[c];
                cnt_q[c]       <= cnt_d[c];
                vol_q[c]       <= vol_d[c];
                rate_q[c]      <= rate_d[c];
                rate_cnt_q[c]  <= rate_cnt_d[c];
                level_q[c]     <= level_d[c];
                gate_q[c]      <= gate_d[c];
                gate_prev_q[c] <= gate_prev_d[c];
                env_en_q[c]    <= env_en_d[c];
                wave_q[c]      <= wave_d[c];
                state_q[c]     <= state_d[c];
            end
            en_q        <= en_d;
            noise_en_q  <= noise_en_d;
            noise_per_q <= noise_per_d;
            noise_vol_q <= noise_vol_d;
            noise_div_q <= noise_div_d;
            lfsr_q      <= lfsr_d;
            presc_q     <= presc_d;
            mix_q       <= mix_d;
            pwm_q       <= pwm_d;
            out_q       <= out_d;
            dbg_q       <= dbg_d;
        end
    end

    assign signal_out = out_q;
    assign debug      = dbg_q;
endmodule
